sipo_deserializer: RTL and testbench

Serial-in/parallel-out receiver, the counterpart to the team's PISO shift register. Samples one bit per qualified clock, assembles a WIDTH-bit word, and presents it on a valid/ready output port. Sits at the receive end of the serial link and feeds downstream parallel logic. Includes a holding register, a sticky overrun flag, and a frame-realign input.

---
 rtl/sipo_deserializer.sv | 103 ++++++++++
 tb/tb_sipo_deserializer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver with a valid/ready holding register,
// sticky overrun flag and frame realign.
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       serial_in,
    input  logic                       shift_en,
    input  logic                       frame_start,
    output logic [WIDTH-1:0]           parallel_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overrun,
    input  logic                       overrun_clr,
    output logic [$clog2(WIDTH+1)-1:0] bit_count
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    logic [WIDTH-1:0] base_sr;
    logic [CW-1:0]    base_cnt;
    logic [WIDTH-1:0] shifted;
    logic             complete;
    logic             consume;
    logic             drop;

    // frame_start realigns first, so a same-edge sample becomes bit 1
    always_comb begin
        base_sr  = frame_start ? '0 : shreg_q;
        base_cnt = frame_start ? '0 : cnt_q;
        if (MSB_FIRST) begin
            shifted = {base_sr[WIDTH-2:0], serial_in};
        end else begin
            shifted = {serial_in, base_sr[WIDTH-1:1]};
        end
        complete = shift_en && (base_cnt == CW'(WIDTH - 1));
        consume  = valid_q && out_ready;
        drop     = complete && valid_q && !out_ready;
    end

    always_comb begin
        shreg_d = base_sr;
        cnt_d   = base_cnt;
        if (complete) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (shift_en) begin
            shreg_d = shifted;
            cnt_d   = base_cnt + CW'(1);
        end
    end

    always_comb begin
        hold_d  = hold_q;
        valid_d = valid_q;
        if (complete && (!valid_q || out_ready)) begin
            hold_d  = shifted;
            valid_d = 1'b1;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    // a drop on the same edge as a clear leaves the flag set
    always_comb begin
        ovr_d = ovr_q;
        if (drop) begin
            ovr_d = 1'b1;
        end else if (overrun_clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign parallel_out = hold_q;
    assign out_valid    = valid_q;
    assign overrun      = ovr_q;
    assign bit_count    = cnt_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer: an MSB-first and an LSB-first
// instance share stimulus; consumed words are checked against queues.
module tb_sipo_deserializer;

    logic       clk = 1'b0;
    logic       rst, serial_in, shift_en, frame_start, out_ready, overrun_clr;
    logic [3:0] pout_m, pout_l;
    logic       valid_m, valid_l, ovr_m, ovr_l;
    logic [2:0] cnt_m, cnt_l;

    int n_pass = 0;
    int n_total = 0;

    logic [3:0] q_m[$];
    logic [3:0] q_l[$];

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .shift_en(shift_en),
        .frame_start(frame_start), .parallel_out(pout_m), .out_valid(valid_m),
        .out_ready(out_ready), .overrun(ovr_m), .overrun_clr(overrun_clr),
        .bit_count(cnt_m)
    );

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .serial_in(serial_in), .shift_en(shift_en),
        .frame_start(frame_start), .parallel_out(pout_l), .out_valid(valid_l),
        .out_ready(out_ready), .overrun(ovr_l), .overrun_clr(overrun_clr),
        .bit_count(cnt_l)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // monitor: pops at each consuming edge, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && valid_m && out_ready) begin
            n_total++;
            if (q_m.size() == 0) begin
                $display("FAIL msb_word: got %b expected none", pout_m);
            end else begin
                logic [3:0] e;
                e = q_m.pop_front();
                if (pout_m === e) n_pass++;
                else $display("FAIL msb_word: got %b expected %b", pout_m, e);
            end
        end
        if (!rst && valid_l && out_ready) begin
            n_total++;
            if (q_l.size() == 0) begin
                $display("FAIL lsb_word: got %b expected none", pout_l);
            end else begin
                logic [3:0] e;
                e = q_l.pop_front();
                if (pout_l === e) n_pass++;
                else $display("FAIL lsb_word: got %b expected %b", pout_l, e);
            end
        end
    end

    task automatic step(input logic se, input logic si, input logic fs,
                        input logic rdy, input logic oc, input logic r);
        shift_en    = se;
        serial_in   = si;
        frame_start = fs;
        out_ready   = rdy;
        overrun_clr = oc;
        rst         = r;
        @(posedge clk);
        #1;
    endtask

    task automatic sh(input logic b, input logic rdy);
        step(1'b1, b, 1'b0, rdy, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 1'b0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] bits;
        rst = 1'b1; serial_in = 1'b0; shift_en = 1'b0;
        frame_start = 1'b0; out_ready = 1'b0; overrun_clr = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_cnt", cnt_m, 0);
        chk("rst_valid", valid_m, 0);
        chk("rst_ovr", ovr_m, 0);
        chk("rst_pout", pout_m, 0);

        // basic word, bit_count 1,2,3,0
        q_m.push_back(4'b1010);
        q_l.push_back(4'b0101);
        sh(1, 0); chk("cnt1", cnt_m, 1);
        sh(0, 0); chk("cnt2", cnt_m, 2);
        sh(1, 0); chk("cnt3", cnt_m, 3);
        chk("valid_pre", valid_m, 0);
        sh(0, 0); chk("cnt0", cnt_m, 0);
        chk("valid1", valid_m, 1);
        chk("pout1", pout_m, 4'b1010);
        chk("pout1_lsb", pout_l, 4'b0101);
        idle(1);
        chk("consumed1", valid_m, 0);

        // back-to-back, consume and complete on the same edge
        q_m.push_back(4'b0011); q_m.push_back(4'b1111);
        q_l.push_back(4'b1100); q_l.push_back(4'b1111);
        bits = 4'b0011;
        for (int i = 3; i >= 0; i--) sh(bits[i], 0);
        sh(1, 0); sh(1, 0); sh(1, 0);
        chk("b2b_hold", pout_m, 4'b0011);
        sh(1, 1);
        chk("b2b_valid", valid_m, 1);
        chk("b2b_pout", pout_m, 4'b1111);
        chk("b2b_ovr", ovr_m, 0);
        idle(1);

        // overrun: second word dropped
        q_m.push_back(4'b0101);
        q_l.push_back(4'b1010);
        bits = 4'b0101;
        for (int i = 3; i >= 0; i--) sh(bits[i], 0);
        bits = 4'b1100;
        for (int i = 3; i >= 0; i--) sh(bits[i], 0);
        chk("ovr_pout", pout_m, 4'b0101);
        chk("ovr_set", ovr_m, 1);
        chk("ovr_valid", valid_m, 1);
        idle(1);
        chk("ovr_consumed", valid_m, 0);
        chk("ovr_sticky", ovr_m, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovr_clr", ovr_m, 0);

        // realign mid-word
        q_m.push_back(4'b0011);
        q_l.push_back(4'b1100);
        sh(1, 0); sh(1, 0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("fs_cnt", cnt_m, 1);
        sh(0, 0); sh(1, 0);
        chk("fs_novalid", valid_m, 0);
        sh(1, 0);
        chk("fs_pout", pout_m, 4'b0011);
        idle(1);

        // reset mid-word
        q_m.push_back(4'b0101);
        q_l.push_back(4'b1010);
        sh(1, 0); sh(1, 0); sh(1, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("mrst_cnt", cnt_m, 0);
        sh(0, 0); sh(1, 0); sh(0, 0);
        chk("mrst_novalid", valid_m, 0);
        sh(1, 0);
        chk("mrst_pout", pout_m, 4'b0101);
        idle(1);

        // gapped shift_en
        q_m.push_back(4'b1001);
        q_l.push_back(4'b1001);
        bits = 4'b1001;
        for (int i = 3; i >= 1; i--) begin
            sh(bits[i], 0);
            for (int g = 0; g < 3; g++) idle(0);
            chk("gap_cnt", cnt_m, 3'(4 - i));
            chk("gap_novalid", valid_m, 0);
        end
        sh(bits[0], 0);
        chk("gap_valid", valid_m, 1);
        chk("gap_pout", pout_m, 4'b1001);
        idle(1);
        idle(0);

        chk("q_m_empty", q_m.size(), 0);
        chk("q_l_empty", q_l.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
